// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, HI/LO read selects and the HI/LO pair type.
package mdu_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned DLEN = 2 * XLEN;

    localparam logic [3:0] MDU_NOP   = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;

    localparam logic [1:0] READ_HI = 2'b01;
    localparam logic [1:0] READ_LO = 2'b10;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_t;

    // Two's-complement negate when neg is set; used for sign/magnitude division.
    function automatic logic [XLEN-1:0] negate_if(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/mdu_unit.sv
// Execute-stage multiply/divide unit: fixed-latency mult/div into HI/LO, mthi/mtlo writes,
// combinational mfhi/mflo read port and a registered busy flag for the hazard unit.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      mdu_op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [1:0]      read_hilo,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    hilo_t            pend_q, pend_d;
    logic             pend_we_q, pend_we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic [DLEN-1:0]  prod_s, prod_u;
    logic [XLEN-1:0]  mag_a, mag_b, sdiv_b, udiv_b;
    logic [XLEN-1:0]  sq, sr, uq, ur;
    logic             div_zero;

    // Full-width arithmetic on the current operands; divisor forced to 1 when zero to keep it defined.
    always_comb begin
        prod_s   = {{XLEN{src_a[XLEN-1]}}, src_a} * {{XLEN{src_b[XLEN-1]}}, src_b};
        prod_u   = {{XLEN{1'b0}}, src_a} * {{XLEN{1'b0}}, src_b};
        div_zero = (src_b == '0);
        mag_a    = negate_if(src_a[XLEN-1], src_a);
        mag_b    = negate_if(src_b[XLEN-1], src_b);
        sdiv_b   = div_zero ? XLEN'(1) : mag_b;
        udiv_b   = div_zero ? XLEN'(1) : src_b;
        sq       = negate_if(src_a[XLEN-1] ^ src_b[XLEN-1], mag_a / sdiv_b);
        sr       = negate_if(src_a[XLEN-1], mag_a % sdiv_b);
        uq       = src_a / udiv_b;
        ur       = src_a % udiv_b;
    end

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_we_d = pend_we_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;

        if (busy_q) begin
            // Commands arriving while busy, including on the commit edge, are dropped.
            if (cnt_q == CNT_W'(1)) begin
                cnt_d  = '0;
                busy_d = 1'b0;
                if (pend_we_q) begin
                    hi_d = pend_q.hi;
                    lo_d = pend_q.lo;
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (start) begin
            case (mdu_op)
                MDU_MULT: begin
                    pend_d    = hilo_t'(prod_s);
                    pend_we_d = 1'b1;
                    cnt_d     = CNT_W'(MULT_CYCLES);
                    busy_d    = 1'b1;
                end
                MDU_MULTU: begin
                    pend_d    = hilo_t'(prod_u);
                    pend_we_d = 1'b1;
                    cnt_d     = CNT_W'(MULT_CYCLES);
                    busy_d    = 1'b1;
                end
                MDU_DIV: begin
                    pend_d    = '{hi: sr, lo: sq};
                    pend_we_d = ~div_zero;
                    cnt_d     = CNT_W'(DIV_CYCLES);
                    busy_d    = 1'b1;
                end
                MDU_DIVU: begin
                    pend_d    = '{hi: ur, lo: uq};
                    pend_we_d = ~div_zero;
                    cnt_d     = CNT_W'(DIV_CYCLES);
                    busy_d    = 1'b1;
                end
                MDU_MTHI: hi_d = src_a;
                MDU_MTLO: lo_d = src_a;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pend_q    <= '0;
            pend_we_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_we_q <= pend_we_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        case (read_hilo)
            READ_HI: result = hi_q;
            READ_LO: result = lo_q;
            default: result = '0;
        endcase
    end

    assign busy = busy_q;
    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule
